// File: rtl/inst_fetch_if.sv
// ---------------------------------------------------------------------------
// inst_fetch_if
//   Bundles the instruction-memory request/response pair, the branch redirect
//   input and the decode-side output handshake of the instruction fetch unit.
//
//   master : fetch side (inst_fetch drives mem_addr and out_*)
//   slave  : memory + decode + branch side (drives mem_inst, redirect_*, out_ready)
//
//   Signals
//     mem_addr        word address to the instruction memory (combinational)
//     mem_inst        memory data for the address sampled at the previous edge
//     redirect_valid  branch taken: restart fetch at redirect_pc
//     redirect_pc     redirect target
//     out_valid       FIFO head valid
//     out_inst        FIFO head instruction (0 when empty)
//     out_pc          fetch address of the head instruction (0 when empty)
//     out_ready       decode accepts the head this cycle
//
//   Handshake: an entry transfers on a rising edge where out_valid and
//   out_ready are both high. out_valid never depends on out_ready. While
//   out_valid is high and out_ready is low, out_inst/out_pc hold their values
//   unless a redirect or reset discards the entry.
// ---------------------------------------------------------------------------
interface inst_fetch_if #(
    parameter int ADDR_W = 64,
    parameter int INST_W = 64
);
    logic [ADDR_W-1:0] mem_addr;
    logic [INST_W-1:0] mem_inst;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_valid;
    logic [INST_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;
    logic              out_ready;

    modport master (
        output mem_addr,
        input  mem_inst,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        output out_inst,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  mem_addr,
        output mem_inst,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        input  out_inst,
        input  out_pc,
        output out_ready
    );
endinterface

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//   Instruction fetch initiator for a synchronous instruction memory with a
//   1-cycle read latency. Owns the PC, issues one word address per cycle when
//   there is room downstream, buffers returned instructions in a small FIFO
//   and presents them to decode. A branch redirect flushes everything not yet
//   delivered and restarts fetch at the target.
//
//   Ports
//     clock        rising-edge clock
//     reset        asynchronous, active-high reset
//     bus          inst_fetch_if.master (memory, redirect and decode signals)
//     o_dbg_count  current FIFO occupancy, for observation only
// ---------------------------------------------------------------------------
module inst_fetch #(
    parameter int                ADDR_W   = 64,
    parameter int                INST_W   = 64,
    parameter int                DEPTH    = 2,
    parameter int                PC_STEP  = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                         clock,
    input  logic                         reset,
    inst_fetch_if.master                 bus,
    output logic [$clog2(DEPTH+1)-1:0]   o_dbg_count
);
    localparam int                PTR_W = $clog2(DEPTH);
    localparam int                CNT_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0] r_pc;       // next address to fetch
    logic              r_req_v;    // a request was issued at the last edge
    logic [ADDR_W-1:0] r_req_pc;   // address of that request
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [INST_W-1:0] r_fifo_inst [DEPTH];
    logic [ADDR_W-1:0] r_fifo_pc   [DEPTH];

    logic              w_valid;
    logic              w_deq;
    logic              w_push;
    logic              w_issue;
    logic [CNT_W:0]    w_occ;

    always_comb begin
        w_valid = (r_count != '0);
        w_deq   = w_valid & bus.out_ready;
        // A redirect discards the response arriving this cycle.
        w_push  = r_req_v & ~bus.redirect_valid;
        // Credit check: entries held + response in flight - entry leaving.
        // Issuing only when this is below DEPTH means the response of every
        // request always finds a free slot one edge later.
        w_occ   = {1'b0, r_count} + (CNT_W+1)'(r_req_v) - (CNT_W+1)'(w_deq);
        w_issue = (w_occ < (CNT_W+1)'(DEPTH));
    end

    always_comb begin
        if (reset) begin
            bus.mem_addr = RESET_PC;
        end else if (bus.redirect_valid) begin
            bus.mem_addr = bus.redirect_pc;
        end else begin
            bus.mem_addr = r_pc;
        end
    end

    assign bus.out_valid = w_valid;
    assign bus.out_inst  = w_valid ? r_fifo_inst[r_rd_ptr] : '0;
    assign bus.out_pc    = w_valid ? r_fifo_pc[r_rd_ptr]   : '0;
    assign o_dbg_count   = r_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_req_v  <= 1'b0;
            r_req_pc <= '0;
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (bus.redirect_valid) begin
            // The redirect target is presented on mem_addr this cycle, so it
            // is already in flight after this edge.
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_req_v  <= 1'b1;
            r_req_pc <= bus.redirect_pc;
            r_pc     <= bus.redirect_pc + STEP;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_deq);
            if (w_issue) begin
                r_req_v  <= 1'b1;
                r_req_pc <= r_pc;
                r_pc     <= r_pc + STEP;
            end else begin
                r_req_v  <= 1'b0;
            end
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_inst[r_wr_ptr] <= bus.mem_inst;
            r_fifo_pc[r_wr_ptr]   <= r_req_pc;
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
  localparam int ADDR_W = 64;
  localparam int INST_W = 64;
  localparam int DEPTH  = 2;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [1:0] dbg_count;

  int n_checks = 0;
  int n_pass   = 0;

  // expected delivery order: consecutive pcs from the last restart point
  logic [63:0] exp_q[$];
  logic [63:0] next_push;

  inst_fetch_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

  inst_fetch #(
    .ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH), .PC_STEP(1), .RESET_PC(RESET_PC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .o_dbg_count(dbg_count)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- memory model: mem[a] = 0x100 + a, one-cycle latency ----------------
  function automatic logic [63:0] mem_word(input logic [63:0] a);
    return a + 64'h100;
  endfunction

  always @(posedge clock) bus.mem_inst <= mem_word(bus.mem_addr);

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic restart(input logic [63:0] pc);
    exp_q.delete();
    next_push = pc;
  endtask

  task automatic top_up();
    while (exp_q.size() < 8) begin
      exp_q.push_back(next_push);
      next_push = next_push + 64'd1;
    end
  endtask

  // ---------------- monitor ----------------
  // Mid-cycle sample: a head seen with out_ready high transfers at the next edge.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_out: got pc 0x%0h expected nothing at %0t", bus.out_pc, $time);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("out_pc", bus.out_pc, e);
          check("out_inst", bus.out_inst, mem_word(e));
        end
      end else if (!bus.out_valid) begin
        check("idle_out_pc", bus.out_pc, 64'h0);
        check("idle_out_inst", bus.out_inst, 64'h0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
    top_up();
  endtask

  // Called at posedge+1; returns at posedge+1 two edges later.
  task automatic do_redirect(input logic [63:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    #1;
    check("redir_mem_addr", bus.mem_addr, target);
    @(posedge clock);
    #1;
    bus.redirect_valid = 1'b0;
    restart(target);
    top_up();
    check("redir_gap_valid", {63'h0, bus.out_valid}, 64'h0);
    @(posedge clock);
    #1;
    top_up();
    check("redir_first_valid", {63'h0, bus.out_valid}, 64'h1);
    check("redir_first_pc", bus.out_pc, target);
  endtask

  // Called at posedge+1; reset pulse lands between edges.
  task automatic async_reset();
    #2;
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    #1;
    check("rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
    check("rst_count", {62'h0, dbg_count}, 64'h0);
    check("rst_mem_addr", bus.mem_addr, RESET_PC);
    restart(RESET_PC);
    top_up();
    @(posedge clock);
    #3;
    reset = 1'b0;
    step();
    check("post_rst_edge1_valid", {63'h0, bus.out_valid}, 64'h0);
    step();
    check("post_rst_edge2_valid", {63'h0, bus.out_valid}, 64'h1);
    check("post_rst_edge2_pc", bus.out_pc, RESET_PC);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic found;
    int r;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b1;
    restart(RESET_PC);
    top_up();

    // reset state
    repeat (3) @(posedge clock);
    #1;
    check("reset_out_valid", {63'h0, bus.out_valid}, 64'h0);
    check("reset_out_pc", bus.out_pc, 64'h0);
    check("reset_out_inst", bus.out_inst, 64'h0);
    check("reset_mem_addr", bus.mem_addr, RESET_PC);
    check("reset_count", {62'h0, dbg_count}, 64'h0);

    // release and first-fetch latency
    @(negedge clock);
    reset = 1'b0;
    step();
    check("lat_edge1_valid", {63'h0, bus.out_valid}, 64'h0);
    step();
    check("lat_edge2_valid", {63'h0, bus.out_valid}, 64'h1);
    check("lat_edge2_pc", bus.out_pc, RESET_PC);

    // sustained streaming: one instruction every cycle
    for (int i = 0; i < 8; i++) begin
      step();
      check("stream_valid", {63'h0, bus.out_valid}, 64'h1);
    end

    // backpressure for 6 cycles: FIFO fills to 2, fetch address holds
    bus.out_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_count", {62'h0, dbg_count}, 64'd2);
      check("bp_head_pc", bus.out_pc, exp_q[0]);
      check("bp_mem_addr", bus.mem_addr, exp_q[0] + 64'd2);
      step();
    end

    // redirect with both entries queued and decode stalled
    do_redirect(64'h10);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();

    // redirect to the top of the address space: wraps to 0
    do_redirect(64'hFFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 6; i++) step();

    // reset mid-stream, then redirect in the same cycle pc 5 is accepted
    async_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.out_valid && exp_q.size() > 0 && exp_q[0] == 64'd5) found = 1'b1;
      else step();
    end
    check("head_pc5_seen", {63'h0, found}, 64'h1);
    if (found) begin
      check("head_pc5_out_pc", bus.out_pc, 64'd5);
      do_redirect(64'h40);
    end
    for (int i = 0; i < 6; i++) step();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 5) begin
        if ($urandom_range(0, 1) == 0) do_redirect({$urandom(), $urandom()});
        else do_redirect(64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3)));
      end else if (r == 5) begin
        async_reset();
      end else begin
        bus.out_ready = ($urandom_range(0, 99) < 70);
        step();
      end
    end

    // drain
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
